// File: rtl/frogger_pkg.sv
// Shared state encoding, field widths and default timing constants for the frogger game-state block.
package frogger_pkg;

    localparam int c_GAME_WIDTH = 3;
    localparam int c_TICK_W     = 6;
    localparam int c_LIVES_W    = 2;
    localparam int c_LEVEL_W    = 3;
    localparam int c_Y_W        = 6;

    localparam logic [c_GAME_WIDTH-1:0] ST_IDLE      = 3'd0;
    localparam logic [c_GAME_WIDTH-1:0] ST_PLAY      = 3'd1;
    localparam logic [c_GAME_WIDTH-1:0] ST_DYING     = 3'd2;
    localparam logic [c_GAME_WIDTH-1:0] ST_GOAL      = 3'd3;
    localparam logic [c_GAME_WIDTH-1:0] ST_GAME_OVER = 3'd4;

    localparam int c_DEF_LIVES       = 3;
    localparam int c_DEF_DEATH_TICKS = 30;
    localparam int c_DEF_GRACE_TICKS = 20;
    localparam int c_DEF_GOAL_Y      = 0;
    localparam int c_DEF_MAX_LEVEL   = 7;

endpackage

// File: rtl/frogger_tick_timer.sv
// Tick-driven down-counter: load wins, otherwise decrements on enabled ticks and stops at zero.
module frogger_tick_timer
    import frogger_pkg::*;
#(
    parameter int c_WIDTH = c_TICK_W
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Tick,
    input  logic               i_En,
    input  logic               i_Load,
    input  logic [c_WIDTH-1:0] i_Load_Val,
    output logic               o_Done
);

    logic [c_WIDTH-1:0] r_Count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Count <= '0;
        end else if (i_Load) begin
            r_Count <= i_Load_Val;
        end else if (i_En && i_Tick && (r_Count != '0)) begin
            r_Count <= r_Count - 1'b1;
        end
    end

    assign o_Done = (r_Count == '0);

endmodule

// File: rtl/frogger_life_manager.sv
// Game-state controller: lives, death/respawn, goal and level. Define FROGGER_GRACE_EN for
// post-respawn collision immunity.
module frogger_life_manager
    import frogger_pkg::*;
#(
`ifdef FROGGER_GRACE_EN
    parameter int c_GRACE_TICKS = c_DEF_GRACE_TICKS,
`endif
    parameter int c_LIVES       = c_DEF_LIVES,
    parameter int c_DEATH_TICKS = c_DEF_DEATH_TICKS,
    parameter int c_GOAL_Y      = c_DEF_GOAL_Y,
    parameter int c_MAX_LEVEL   = c_DEF_MAX_LEVEL
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Tick,
    input  logic                    i_Start,
    input  logic                    i_Collided,
    input  logic [c_Y_W-1:0]        i_Frogger_Y,
    output logic [c_LIVES_W-1:0]    o_Lives,
    output logic [c_LEVEL_W-1:0]    o_Level,
    output logic                    o_Respawn,
    output logic                    o_Freeze,
    output logic                    o_Game_Over,
    output logic [c_GAME_WIDTH-1:0] o_State
);

    logic [c_GAME_WIDTH-1:0] r_State, w_Next_State;
    logic [c_LIVES_W-1:0]    r_Lives, w_Next_Lives;
    logic [c_LEVEL_W-1:0]    r_Level, w_Next_Level;
    logic                    r_Respawn, r_Freeze, r_Game_Over;
    logic                    w_Next_Respawn;
    logic                    w_Death_Load, w_Death_Done;
    logic [c_TICK_W-1:0]     w_Death_Val;
    logic                    w_Grace;

    // The load on DYING entry overrides any tick in the collision cycle, so that tick is not counted.
    frogger_tick_timer #(.c_WIDTH(c_TICK_W)) u_death_timer (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Tick     (i_Tick),
        .i_En       (r_State == ST_DYING),
        .i_Load     (w_Death_Load),
        .i_Load_Val (w_Death_Val),
        .o_Done     (w_Death_Done)
    );

`ifdef FROGGER_GRACE_EN
    logic w_Grace_Done;
    logic w_Grace_Load;
    logic [c_TICK_W-1:0] w_Grace_Val;

    // Armed on every respawn, forced to zero whenever PLAY is left.
    assign w_Grace_Load = w_Next_Respawn || ((r_State == ST_PLAY) && (w_Next_State != ST_PLAY));
    assign w_Grace_Val  = w_Next_Respawn ? c_TICK_W'(c_GRACE_TICKS) : '0;

    frogger_tick_timer #(.c_WIDTH(c_TICK_W)) u_grace_timer (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Tick     (i_Tick),
        .i_En       (r_State == ST_PLAY),
        .i_Load     (w_Grace_Load),
        .i_Load_Val (w_Grace_Val),
        .o_Done     (w_Grace_Done)
    );

    assign w_Grace = !w_Grace_Done;
`else
    assign w_Grace = 1'b0;
`endif

    always_comb begin
        w_Next_State = r_State;
        w_Next_Lives = r_Lives;
        w_Next_Level = r_Level;
        w_Death_Load = 1'b0;
        w_Death_Val  = c_TICK_W'(c_DEATH_TICKS - 1);
        case (r_State)
            ST_IDLE: begin
                if (i_Start) begin
                    w_Next_State = ST_PLAY;
                    w_Next_Lives = c_LIVES_W'(c_LIVES);
                    w_Next_Level = '0;
                end
            end
            ST_PLAY: begin
                // Collision takes priority over a goal in the same cycle.
                if (i_Collided && !w_Grace && (r_Lives != '0)) begin
                    w_Next_State = ST_DYING;
                    w_Next_Lives = r_Lives - 1'b1;
                    w_Death_Load = 1'b1;
                end else if (i_Frogger_Y == c_Y_W'(c_GOAL_Y)) begin
                    w_Next_State = ST_GOAL;
                    w_Death_Load = 1'b1;
                    w_Death_Val  = '0;
                end
            end
            ST_DYING: begin
                if (i_Tick && w_Death_Done) begin
                    w_Next_State = (r_Lives == '0) ? ST_GAME_OVER : ST_PLAY;
                end
            end
            ST_GOAL: begin
                w_Next_State = ST_PLAY;
                if (r_Level < c_LEVEL_W'(c_MAX_LEVEL)) begin
                    w_Next_Level = r_Level + 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (i_Start) begin
                    w_Next_State = ST_IDLE;
                end
            end
            default: w_Next_State = ST_IDLE;
        endcase
    end

    assign w_Next_Respawn = (w_Next_State == ST_PLAY) && (r_State != ST_PLAY);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= ST_IDLE;
            r_Lives     <= '0;
            r_Level     <= '0;
            r_Respawn   <= 1'b0;
            r_Freeze    <= 1'b1;
            r_Game_Over <= 1'b0;
        end else begin
            r_State     <= w_Next_State;
            r_Lives     <= w_Next_Lives;
            r_Level     <= w_Next_Level;
            r_Respawn   <= w_Next_Respawn;
            r_Freeze    <= (w_Next_State != ST_PLAY);
            r_Game_Over <= (w_Next_State == ST_GAME_OVER);
        end
    end

    assign o_State     = r_State;
    assign o_Lives     = r_Lives;
    assign o_Level     = r_Level;
    assign o_Respawn   = r_Respawn;
    assign o_Freeze    = r_Freeze;
    assign o_Game_Over = r_Game_Over;

endmodule

// File: tb/tb_frogger_life_manager.sv
// Directed bench for frogger_life_manager; covers the grace window when FROGGER_GRACE_EN is defined.
module tb_frogger_life_manager;

    localparam int DEATH = 30;
`ifdef FROGGER_GRACE_EN
    localparam int GRACE_WAIT = 20;
`else
    localparam int GRACE_WAIT = 0;
`endif

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Tick = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Collided = 1'b0;
    logic [5:0] i_Frogger_Y = 6'd10;
    logic [1:0] o_Lives;
    logic [2:0] o_Level;
    logic       o_Respawn;
    logic       o_Freeze;
    logic       o_Game_Over;
    logic [2:0] o_State;

    int n_chk = 0;
    int n_err = 0;

    frogger_life_manager dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Tick      (i_Tick),
        .i_Start     (i_Start),
        .i_Collided  (i_Collided),
        .i_Frogger_Y (i_Frogger_Y),
        .o_Lives     (o_Lives),
        .o_Level     (o_Level),
        .o_Respawn   (o_Respawn),
        .o_Freeze    (o_Freeze),
        .o_Game_Over (o_Game_Over),
        .o_State     (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] lives,
                           input logic [2:0] lvl, input logic resp, input logic frz, input logic go);
        chk({tag, ".state"},   8'(o_State),     8'(st));
        chk({tag, ".lives"},   8'(o_Lives),     8'(lives));
        chk({tag, ".level"},   8'(o_Level),     8'(lvl));
        chk({tag, ".respawn"}, 8'(o_Respawn),   8'(resp));
        chk({tag, ".freeze"},  8'(o_Freeze),    8'(frz));
        chk({tag, ".gameover"},8'(o_Game_Over), 8'(go));
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            i_Tick = 1'b1;
            step();
            i_Tick = 1'b0;
            step();
        end
    endtask

    // Collide (after pre ticks), sit through the full death, check where it lands.
    task automatic kill(input int pre, input logic [1:0] lives_after, input logic [2:0] lvl,
                        input logic [2:0] end_st);
        tick_n(pre);
        i_Collided = 1'b1;
        i_Tick = 1'b1;
        step();
        i_Collided = 1'b0;
        i_Tick = 1'b0;
        chk_all("dying_entry", 3'd2, lives_after, lvl, 1'b0, 1'b1, 1'b0);
        step();
        i_Collided = 1'b1;
        i_Start = 1'b1;
        step();
        i_Collided = 1'b0;
        i_Start = 1'b0;
        chk("dying_ignores.state", 8'(o_State), 8'd2);
        chk("dying_ignores.lives", 8'(o_Lives), 8'(lives_after));
        tick_n(DEATH - 1);
        chk("dying_before_last.state", 8'(o_State), 8'd2);
        i_Tick = 1'b1;
        step();
        i_Tick = 1'b0;
        chk_all("dying_exit", end_st, lives_after, lvl, (end_st == 3'd1), (end_st != 3'd1),
                (end_st == 3'd4));
    endtask

    initial begin
        repeat (3) step();
        chk_all("reset", 3'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        step();
        step();
        chk_all("idle_hold", 3'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);

        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        chk_all("start", 3'd1, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0);

`ifdef FROGGER_GRACE_EN
        tick_n(5);
        i_Collided = 1'b1;
        step();
        i_Collided = 1'b0;
        chk("grace_ignore.state", 8'(o_State), 8'd1);
        chk("grace_ignore.lives", 8'(o_Lives), 8'd3);
        tick_n(15);
        kill(0, 2'd2, 3'd0, 3'd1);
`else
        kill(0, 2'd2, 3'd0, 3'd1);
`endif
        step();
        chk("respawn_one_cycle", 8'(o_Respawn), 8'd0);

        kill(GRACE_WAIT, 2'd1, 3'd0, 3'd1);
        kill(GRACE_WAIT, 2'd0, 3'd0, 3'd4);

        i_Collided = 1'b1;
        step();
        i_Collided = 1'b0;
        chk_all("game_over_hold", 3'd4, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        chk_all("go_to_idle", 3'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        chk_all("restart", 3'd1, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0);

        for (int g = 1; g <= 8; g++) begin
            i_Frogger_Y = 6'd0;
            step();
            i_Frogger_Y = 6'd10;
            chk("goal.state", 8'(o_State), 8'd3);
            step();
            chk_all("goal_exit", 3'd1, 2'd3, (g > 7) ? 3'd7 : 3'(g), 1'b1, 1'b0, 1'b0);
        end

        tick_n(GRACE_WAIT);
        i_Frogger_Y = 6'd0;
        i_Collided = 1'b1;
        step();
        i_Frogger_Y = 6'd10;
        i_Collided = 1'b0;
        chk_all("collide_beats_goal", 3'd2, 2'd2, 3'd7, 1'b0, 1'b1, 1'b0);

        step();
        tick_n(15);
        chk("mid_dying.state", 8'(o_State), 8'd2);
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk_all("async_reset", 3'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        step();
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        chk_all("post_reset_start", 3'd1, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0);
        kill(GRACE_WAIT, 2'd2, 3'd0, 3'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
